// File: rtl/sha3_ctrl_pkg.sv
// Shared types and constants for the SHA3 job controller and its result serializer.
package sha3_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_ARM,
    ST_LAUNCH,
    ST_RUN,
    ST_REPORT
  } ctrl_state_e;

  localparam int JOB_WORDS          = 26;
  localparam int BASE_NONCE_IDX     = 21;
  localparam int STAT_FOUND_BIT     = 0;
  localparam int STAT_EXHAUSTED_BIT = 1;
  localparam int STAT_SEQ_LSB       = 16;

  function automatic logic [31:0] status_word(input logic found, input logic [15:0] seq);
    status_word                          = '0;
    status_word[STAT_FOUND_BIT]          = found;
    status_word[STAT_EXHAUSTED_BIT]      = ~found;
    status_word[STAT_SEQ_LSB +: 16]      = seq;
  endfunction

endpackage

// File: rtl/sha3_result_serializer.sv
// Captures one scan result into a shadow and streams it as status, nonce, hash words.
module sha3_result_serializer
  import sha3_ctrl_pkg::*;
#(
  parameter int HASH_WORDS = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       capture_i,
  input  logic                       found_i,
  input  logic [31:0]                nonce_i,
  input  logic [HASH_WORDS-1:0][31:0] hash_i,
  input  logic [15:0]                seq_i,
  input  logic                       out_ready_i,
  output logic [31:0]                out_data_o,
  output logic                       out_valid_o,
  output logic                       out_last_o,
  output logic                       done_o
);

  localparam int LAST_IDX = HASH_WORDS + 1;
  localparam int IDX_W    = $clog2(HASH_WORDS + 2);

  logic                        valid_q;
  logic [IDX_W-1:0]            idx_q;
  logic                        found_q;
  logic [31:0]                 nonce_q;
  logic [HASH_WORDS-1:0][31:0] hash_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      found_q <= 1'b0;
      nonce_q <= '0;
      hash_q  <= '0;
    end else if (capture_i) begin
      valid_q <= 1'b1;
      idx_q   <= '0;
      found_q <= found_i;
      nonce_q <= nonce_i;
      hash_q  <= hash_i;
    end else if (valid_q && out_ready_i) begin
      if (out_last_o) begin
        valid_q <= 1'b0;
        idx_q   <= '0;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  // An exhausted scan reports zeros for everything after the status word.
  always_comb begin
    out_data_o = '0;
    if (idx_q == '0) begin
      out_data_o = status_word(found_q, seq_i);
    end else if (found_q) begin
      if (idx_q == IDX_W'(1)) out_data_o = nonce_q;
      for (int k = 0; k < HASH_WORDS; k++) begin
        if (idx_q == IDX_W'(k + 2)) out_data_o = hash_q[k];
      end
    end
  end

  assign out_valid_o = valid_q;
  assign out_last_o  = valid_q && (idx_q == IDX_W'(LAST_IDX));
  assign done_o      = out_last_o && out_ready_i;

endmodule

// File: rtl/sha3_job_controller.sv
// Loads a 26-word job, launches the nonce scanner, tracks it to completion and returns the result frame.
module sha3_job_controller
  import sha3_ctrl_pkg::*;
#(
  parameter int HASH_WORDS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [31:0]         out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                scan_start,
  output logic [63:0]         scan_threshold,
  output logic [23:0][31:0]   scan_blobby,
  input  logic                scan_dispatching,
  input  logic                scan_ready,
  input  logic                scan_found,
  input  logic [31:0]         scan_nonce,
  input  logic [24:0][63:0]   scan_hash,
  output logic                busy
);

  ctrl_state_e                state_q;
  logic [4:0]                 cnt_q;
  logic [15:0]                seq_q;
  logic [JOB_WORDS-1:0][31:0] job_q;
  logic                       in_ready_q;
  logic                       busy_q;

  logic                        capture;
  logic                        ser_done;
  logic [31:0]                 abs_nonce;
  logic [HASH_WORDS-1:0][31:0] hash_words;

  // Result is taken once the scanner has stopped issuing and its pipeline has drained.
  assign capture    = (state_q == ST_RUN) && !scan_dispatching && scan_ready;
  assign scan_start = (state_q == ST_ARM) && scan_ready;
  assign abs_nonce  = job_q[BASE_NONCE_IDX + 2] + scan_nonce;
  // Lane k of the hash splits into word 2k (low half) and 2k+1 (high half).
  assign hash_words = scan_hash[HASH_WORDS/2-1:0];

  assign scan_threshold = {job_q[1], job_q[0]};
  assign scan_blobby    = job_q[JOB_WORDS-1:2];
  assign in_ready       = in_ready_q;
  assign busy           = busy_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      cnt_q      <= '0;
      seq_q      <= '0;
      job_q      <= '0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (in_valid && in_ready_q) begin
            job_q[cnt_q] <= in_data;
            if (cnt_q == 5'(JOB_WORDS - 1)) begin
              cnt_q      <= '0;
              state_q    <= ST_ARM;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end
        ST_ARM:    if (scan_ready) state_q <= ST_LAUNCH;
        ST_LAUNCH: if (scan_dispatching) state_q <= ST_RUN;
        ST_RUN:    if (capture) state_q <= ST_REPORT;
        ST_REPORT: begin
          if (ser_done) begin
            state_q    <= ST_LOAD;
            seq_q      <= seq_q + 16'd1;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  sha3_result_serializer #(
    .HASH_WORDS(HASH_WORDS)
  ) u_serializer (
    .clk        (clk),
    .rst_n      (rst_n),
    .capture_i  (capture),
    .found_i    (scan_found),
    .nonce_i    (abs_nonce),
    .hash_i     (hash_words),
    .seq_i      (seq_q),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_valid_o(out_valid),
    .out_last_o (out_last),
    .done_o     (ser_done)
  );

endmodule
